// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode and ASCII operator character constants shared by the ALU, its interface FSM and the ASCII translator
package alu_pkg;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_AMP   = 8'h26;
    localparam logic [7:0] CH_PIPE  = 8'h7C;
    localparam logic [7:0] CH_CARET = 8'h5E;
    localparam logic [7:0] CH_TILDE = 8'h7E;
    localparam logic [7:0] CH_GT    = 8'h3E;
    localparam logic [7:0] CH_LT    = 8'h3C;

    localparam logic [7:0] CH_A_UC = 8'h41;
    localparam logic [7:0] CH_A_LC = 8'h61;
    localparam logic [7:0] CH_S_UC = 8'h53;
    localparam logic [7:0] CH_S_LC = 8'h73;
    localparam logic [7:0] CH_N_UC = 8'h4E;
    localparam logic [7:0] CH_N_LC = 8'h6E;
    localparam logic [7:0] CH_O_UC = 8'h4F;
    localparam logic [7:0] CH_O_LC = 8'h6F;
    localparam logic [7:0] CH_X_UC = 8'h58;
    localparam logic [7:0] CH_X_LC = 8'h78;
    localparam logic [7:0] CH_R_UC = 8'h52;
    localparam logic [7:0] CH_R_LC = 8'h72;
    localparam logic [7:0] CH_H_UC = 8'h48;
    localparam logic [7:0] CH_H_LC = 8'h68;
    localparam logic [7:0] CH_L_UC = 8'h4C;
    localparam logic [7:0] CH_L_LC = 8'h6C;
endpackage

// File: rtl/ascii_op_lut.sv
// ascii_op_lut: combinational ASCII-to-opcode lookup
// Ports: ascii_in (character), hit (character recognised), op (opcode, 0 on miss)
// CONV_ASCII_MNEMONIC_EN: also accept upper/lower case letter mnemonics
module ascii_op_lut
    import alu_pkg::*;
(
    input  logic [7:0] ascii_in,
    output logic       hit,
    output logic [7:0] op
);
    always_comb begin
        hit = 1'b1;
        op  = 8'h00;
        case (ascii_in)
            CH_PLUS:  op = OP_ADD;
            CH_MINUS: op = OP_SUB;
            CH_AMP:   op = OP_AND;
            CH_PIPE:  op = OP_OR;
            CH_CARET: op = OP_XOR;
            CH_TILDE: op = OP_NOR;
            CH_GT:    op = OP_SRA;
            CH_LT:    op = OP_SRL;
`ifdef CONV_ASCII_MNEMONIC_EN
            CH_A_UC, CH_A_LC: op = OP_ADD;
            CH_S_UC, CH_S_LC: op = OP_SUB;
            CH_N_UC, CH_N_LC: op = OP_AND;
            CH_O_UC, CH_O_LC: op = OP_OR;
            CH_X_UC, CH_X_LC: op = OP_XOR;
            CH_R_UC, CH_R_LC: op = OP_NOR;
            CH_H_UC, CH_H_LC: op = OP_SRA;
            CH_L_UC, CH_L_LC: op = OP_SRL;
`endif
            default: hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/conv_ascii_opcode.sv
// conv_ascii_opcode: registered ASCII operator character to ALU opcode translator
// Ports: clk, reset (sync, active-high), ascii_in/in_valid (UART byte strobe),
//        opcode (registered opcode), out_valid (one-cycle update pulse), err (last byte unrecognised)
// CONV_ASCII_MNEMONIC_EN: also accept letter mnemonics (handled in ascii_op_lut)
module conv_ascii_opcode
    import alu_pkg::*;
#(
    parameter logic [7:0] ERR_OPCODE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       in_valid,
    output logic [7:0] opcode,
    output logic       out_valid,
    output logic       err
);
    logic       hit;
    logic [7:0] op;
    logic [7:0] opcode_q, opcode_d;
    logic       err_q, err_d, out_valid_q;

    ascii_op_lut u_lut (
        .ascii_in(ascii_in),
        .hit     (hit),
        .op      (op)
    );

    always_comb begin
        opcode_d = in_valid ? (hit ? op : ERR_OPCODE) : opcode_q;
        err_d    = in_valid ? ~hit : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q    <= ERR_OPCODE;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            err_q       <= err_d;
            out_valid_q <= in_valid;
        end
    end

    assign opcode    = opcode_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_conv_ascii_opcode.sv
// tb_conv_ascii_opcode: self-checking bench for conv_ascii_opcode against a table-driven reference model
module tb_conv_ascii_opcode;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ascii_in = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] opcode;
    logic       out_valid;
    logic       err;

    int total = 0;
    int bad = 0;

    logic [8:0] map [256];
    logic [7:0] exp_op = 8'h00;
    logic       exp_err = 1'b0;
    logic       exp_ov = 1'b0;

    conv_ascii_opcode dut (
        .clk      (clk),
        .reset    (reset),
        .ascii_in (ascii_in),
        .in_valid (in_valid),
        .opcode   (opcode),
        .out_valid(out_valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [7:0] ch, input string tag);
        reset = rst;
        in_valid = v;
        ascii_in = ch;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_op = 8'h00;
            exp_err = 1'b0;
            exp_ov = 1'b0;
        end else begin
            exp_ov = v;
            if (v) begin
                exp_op = map[ch][8] ? map[ch][7:0] : 8'h00;
                exp_err = ~map[ch][8];
            end
        end
        check({tag, ".opcode"}, opcode, exp_op);
        check({tag, ".err"}, {7'd0, err}, {7'd0, exp_err});
        check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, exp_ov});
    endtask

    initial begin
        logic [7:0] syms [8] = '{8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E, 8'h7E, 8'h3E, 8'h3C};
        logic [7:0] ops  [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        logic [7:0] lets [8] = '{"a", "s", "n", "o", "x", "r", "h", "l"};
        for (int i = 0; i < 256; i++) map[i] = 9'h000;
        for (int i = 0; i < 8; i++) begin
            map[syms[i]] = {1'b1, ops[i]};
`ifdef CONV_ASCII_MNEMONIC_EN
            map[lets[i]] = {1'b1, ops[i]};
            map[lets[i] - 8'd32] = {1'b1, ops[i]};
`else
            if (lets[i] == 8'h00) map[0] = 9'h000;
`endif
        end

        step(1'b1, 1'b0, 8'h00, "reset0");
        step(1'b1, 1'b0, 8'h00, "reset1");
        step(1'b0, 1'b0, 8'h00, "idle");
        check("idle_lit", opcode, 8'h00);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, syms[i], $sformatf("sym%0d", i));
        step(1'b0, 1'b1, 8'h2B, "plus");
        check("plus_lit", opcode, 8'h20);
        step(1'b0, 1'b1, 8'h3C, "lt");
        check("lt_lit", opcode, 8'h02);
        step(1'b0, 1'b1, 8'hAB, "bit7");
        check("bit7_err_lit", {7'd0, err}, 8'h01);

        step(1'b0, 1'b1, 8'h51, "badQ");
        check("badQ_err_lit", {7'd0, err}, 8'h01);
        step(1'b0, 1'b1, 8'h5E, "caret");
        check("caret_lit", opcode, 8'h26);

        step(1'b0, 1'b1, 8'h2D, "minus");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h2B, "hold");
        check("hold_lit", opcode, 8'h22);

        step(1'b0, 1'b1, 8'h2B, "pre_coll");
        step(1'b1, 1'b1, 8'h26, "collision");
        check("coll_lit", opcode, 8'h00);
        step(1'b0, 1'b0, 8'h26, "post_coll");

        step(1'b0, 1'b1, "x", "mn_x");
`ifdef CONV_ASCII_MNEMONIC_EN
        check("mn_x_lit", opcode, 8'h26);
        step(1'b0, 1'b1, "L", "mn_L");
        check("mn_L_lit", opcode, 8'h02);
        step(1'b0, 1'b1, 8'h41, "mn_A");
        check("mn_A_lit", opcode, 8'h20);
`else
        check("mn_x_err_lit", {7'd0, err}, 8'h01);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [7:0] ch;
            ch = ($urandom_range(0, 1) == 0) ? syms[$urandom_range(0, 7)] : 8'($urandom);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, ch, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
